// File: rtl/pu_program_loader_if.sv
// Byte-stream input and program-memory write port of the microcode program loader.
// The loader uses the slave view; the host/memory side uses the master view.
interface pu_program_loader_if #(
    parameter int MICROCODE_WIDTH = 16,
    parameter int PROGRAM_SIZE    = 200,
    parameter int ADDR_WIDTH      = $clog2(PROGRAM_SIZE)
);
    logic [7:0]                 in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       mem_we;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [MICROCODE_WIDTH-1:0] mem_data;

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_data
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/pu_program_loader.sv
// Loads a framed, XOR-checksummed byte stream into microcode program memory and
// keeps the sequencer in reset until the whole frame has been verified.
module pu_program_loader #(
    parameter int MICROCODE_WIDTH = 16,
    parameter int PROGRAM_SIZE    = 200,
    parameter int ADDR_WIDTH      = $clog2(PROGRAM_SIZE),
    parameter int BYTES_PER_WORD  = (MICROCODE_WIDTH + 7) / 8
) (
    input  logic                clk,
    input  logic                rst,
    pu_program_loader_if.slave  bus,
    output logic                sequencer_rst,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int BUF_W  = BYTES_PER_WORD * 8;
    localparam int BIDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [15:0] MAX_LEN = 16'(PROGRAM_SIZE);

    localparam logic [2:0] ST_LEN_LO = 3'd0;
    localparam logic [2:0] ST_LEN_HI = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    logic [2:0]            state;
    logic [15:0]           len;
    logic [7:0]            csum_acc;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [BIDX_W-1:0]     byte_idx;
    logic [BUF_W-1:0]      word_buf;
    logic [BUF_W-1:0]      assembled;
    logic                  xfer;
    logic                  last_byte;
    logic                  last_word;

    // CHECK is the only state that refuses bytes; ERROR keeps draining the stream.
    assign bus.in_ready = (state != ST_CHECK);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign busy         = (state != ST_LEN_LO);
    assign last_byte    = (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));
    assign last_word    = (32'(word_idx) == (32'(len) - 32'd1));

    // The final byte of a word goes straight into the write data, so the word
    // is written one cycle after its last handshake without an extra stage.
    always_comb begin
        assembled = word_buf;
        assembled[BUF_W-1 -: 8] = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_LEN_LO;
            len           <= '0;
            csum_acc      <= '0;
            word_idx      <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            sequencer_rst <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            done       <= 1'b0;
            case (state)
                ST_LEN_LO: begin
                    if (xfer) begin
                        len[7:0]      <= bus.in_data;
                        csum_acc      <= bus.in_data;
                        sequencer_rst <= 1'b1;
                        state         <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.in_data;
                        csum_acc  <= csum_acc ^ bus.in_data;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (len == 16'd0 || len > MAX_LEN) begin
                        error <= 1'b1;
                        state <= ST_ERROR;
                    end else begin
                        word_idx <= '0;
                        byte_idx <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        csum_acc <= csum_acc ^ bus.in_data;
                        word_buf[{byte_idx, 3'b000} +: 8] <= bus.in_data;
                        if (last_byte) begin
                            byte_idx     <= '0;
                            bus.mem_we   <= 1'b1;
                            bus.mem_addr <= word_idx;
                            bus.mem_data <= assembled[MICROCODE_WIDTH-1:0];
                            if (last_word) begin
                                state <= ST_CSUM;
                            end else begin
                                word_idx <= word_idx + ADDR_WIDTH'(1);
                            end
                        end else begin
                            byte_idx <= byte_idx + BIDX_W'(1);
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        if (bus.in_data == csum_acc) begin
                            sequencer_rst <= 1'b0;
                            done          <= 1'b1;
                            state         <= ST_LEN_LO;
                        end else begin
                            error <= 1'b1;
                            state <= ST_ERROR;
                        end
                    end
                end
                default: begin
                    // ERROR (and any illegal encoding) is held until rst.
                    error         <= 1'b1;
                    sequencer_rst <= 1'b1;
                    state         <= ST_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_program_loader.sv
// Directed and randomized frames for pu_program_loader, checked against a
// frame-level model of the expected writes, pulses and error behaviour.
module tb_pu_program_loader;

    localparam int MW  = 16;
    localparam int PS  = 200;
    localparam int AW  = $clog2(PS);
    localparam int BPW = (MW + 7) / 8;

    logic clk = 1'b0;
    logic rst;
    logic sequencer_rst;
    logic busy;
    logic done;
    logic error;

    int total = 0;
    int bad   = 0;

    logic [7:0]    frame[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [MW-1:0] wr_data_q[$];
    int            ready_low_cnt = 0;
    int            done_cnt      = 0;

    pu_program_loader_if #(.MICROCODE_WIDTH(MW), .PROGRAM_SIZE(PS), .ADDR_WIDTH(AW)) bus ();

    pu_program_loader #(
        .MICROCODE_WIDTH(MW),
        .PROGRAM_SIZE(PS),
        .ADDR_WIDTH(AW),
        .BYTES_PER_WORD(BPW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .sequencer_rst(sequencer_rst),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    // Log every write, done pulse and stalled cycle just after each edge.
    always @(posedge clk) begin
        #1;
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_data);
        end
        if (bus.in_ready === 1'b0) ready_low_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte; returns at the falling edge right after its handshake.
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        waited = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_xfer", bus.in_ready, 1);
        @(negedge clk);
    endtask

    task automatic idleCycles(input int k);
        bus.in_valid = 1'b0;
        repeat (k) begin
            @(negedge clk);
            checkOutput("idle_mem_we", bus.mem_we, 0);
            checkOutput("idle_done", done, 0);
        end
    endtask

    task automatic doReset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_mem_we", bus.mem_we, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_mem_data", bus.mem_data, 0);
        checkOutput("rst_seq_rst", sequencer_rst, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
    endtask

    task automatic buildFrame(input int n, input bit corrupt);
        logic [7:0] x;
        frame = {};
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        for (int i = 0; i < n * BPW; i++) frame.push_back(8'($urandom));
        x = 8'h00;
        foreach (frame[i]) x ^= frame[i];
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        frame.push_back(x);
    endtask

    // gap_mode: 0 = back-to-back, 1 = one idle cycle per byte, 2 = random idles.
    task automatic runFrame(input int gap_mode);
        int            n;
        int            data_end;
        int            wr_base;
        int            rl_base;
        int            dn_base;
        int            nwr;
        bit            len_ok;
        bit            err;
        bit            this_done;
        bit            any_done;
        bit            exp_we;
        logic [7:0]    x_run;
        logic [31:0]   w;
        logic [MW-1:0] words[$];

        n        = int'({frame[1], frame[0]});
        len_ok   = (n >= 1) && (n <= PS);
        data_end = 2 + n * BPW;
        words    = {};
        if (len_ok) begin
            for (int k = 0; k < n; k++) begin
                w = 32'd0;
                for (int b = 0; b < BPW; b++) w = w | (32'(frame[2 + k * BPW + b]) << (8 * b));
                words.push_back(w[MW-1:0]);
            end
        end

        wr_base  = wr_addr_q.size();
        rl_base  = ready_low_cnt;
        dn_base  = done_cnt;
        x_run    = 8'h00;
        err      = 1'b0;
        any_done = 1'b0;

        for (int i = 0; i < frame.size(); i++) begin
            applyStimulus(frame[i]);
            this_done = 1'b0;
            exp_we    = len_ok && !err && i >= 2 && i < data_end && ((i - 2) % BPW) == BPW - 1;
            if (!len_ok && i >= 2) err = 1'b1;
            if (len_ok && i == data_end && !err) begin
                this_done = (frame[i] == x_run);
                err       = !this_done;
                any_done  = this_done;
            end else begin
                x_run ^= frame[i];
            end
            checkOutput("in_ready", bus.in_ready, (i == 1) ? 0 : 1);
            checkOutput("mem_we", bus.mem_we, exp_we);
            if (exp_we) begin
                checkOutput("mem_addr", bus.mem_addr, (i - 2) / BPW);
                checkOutput("mem_data", bus.mem_data, words[(i - 2) / BPW]);
            end
            checkOutput("done", done, this_done);
            checkOutput("error", error, err);
            checkOutput("seq_rst", sequencer_rst, !this_done);
            checkOutput("busy", busy, !this_done);
            if (gap_mode == 1) idleCycles(1);
            else if (gap_mode == 2) idleCycles($urandom_range(0, 2));
        end

        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("pulse_end_we", bus.mem_we, 0);
        checkOutput("pulse_end_done", done, 0);
        if (!len_ok) err = 1'b1;
        checkOutput("error_final", error, err);

        nwr = wr_addr_q.size() - wr_base;
        checkOutput("write_count", nwr, words.size());
        for (int k = 0; k < words.size() && k < nwr; k++) begin
            checkOutput("log_addr", wr_addr_q[wr_base + k], k);
            checkOutput("log_data", wr_data_q[wr_base + k], words[k]);
        end
        checkOutput("ready_low_cycles", ready_low_cnt - rl_base, 1);
        checkOutput("done_count", done_cnt - dn_base, any_done);
    endtask

    initial begin
        int  base;
        bit  corrupt;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(negedge clk);
        doReset();

        $display("[TB] good frame");
        frame = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
        runFrame(0);

        $display("[TB] bad checksum");
        frame = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B};
        runFrame(0);
        base = wr_addr_q.size();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'($urandom));
            checkOutput("err_drain_we", bus.mem_we, 0);
            checkOutput("err_drain_error", error, 1);
            checkOutput("err_drain_seq_rst", sequencer_rst, 1);
        end
        idleCycles(1);
        checkOutput("err_drain_writes", wr_addr_q.size() - base, 0);
        doReset();

        $display("[TB] length bounds");
        frame = {8'h00, 8'h00};
        runFrame(0);
        doReset();
        frame = {8'hC9, 8'h00};
        runFrame(0);
        doReset();
        buildFrame(PS, 1'b0);
        runFrame(0);

        $display("[TB] gapped valid");
        frame = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
        runFrame(1);

        $display("[TB] reset mid-load");
        base  = wr_addr_q.size();
        frame = {8'h02, 8'h00, 8'h34, 8'h12};
        foreach (frame[i]) applyStimulus(frame[i]);
        checkOutput("midload_we", bus.mem_we, 1);
        checkOutput("midload_addr", bus.mem_addr, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midload_rst_we", bus.mem_we, 0);
        checkOutput("midload_rst_busy", busy, 0);
        checkOutput("midload_rst_seq_rst", sequencer_rst, 0);
        checkOutput("midload_rst_ready", bus.in_ready, 1);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h34);
        bus.in_data  = 8'h12;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("cancel_we", bus.mem_we, 0);
        checkOutput("cancel_busy", busy, 0);
        checkOutput("midload_writes", wr_addr_q.size() - base, 1);
        frame = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A};
        runFrame(0);

        $display("[TB] random frames");
        for (int r = 0; r < 8; r++) begin
            corrupt = ($urandom_range(0, 3) == 0);
            buildFrame($urandom_range(1, 8), corrupt);
            runFrame($urandom_range(0, 2));
            if (corrupt) doReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pu_program_loader.md
Name: pu_program_loader

Overview:
- Upstream feeder for the microcode sequencer's program memory.
- Receives a framed byte stream from the host link (valid/ready), assembles MICROCODE_WIDTH-bit microcode words and writes them into program memory through a write port.
- Holds the sequencer in reset while a program is being loaded, and releases it only after the frame checksum is verified.

Parameters:
- MICROCODE_WIDTH, 16, width of one microcode word.
- PROGRAM_SIZE, 200, program memory depth in words; this is the maximum frame length.
- ADDR_WIDTH, $clog2(PROGRAM_SIZE), width of mem_addr.
- BYTES_PER_WORD, (MICROCODE_WIDTH+7)/8, derived; stream bytes per word.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- mem_we  out  1  program memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  MICROCODE_WIDTH  write data.
- sequencer_rst  out  1  holds the downstream sequencer in reset.
- busy  out  1  a frame is in progress (state not LEN_LO).
- done  out  1  one-cycle pulse on successful load.
- error  out  1  sticky frame error.

Behaviour:
- Frame format, all fields little-endian:
  - LEN: 2 bytes, N = number of words.
  - N words, BYTES_PER_WORD bytes each, low byte first. Bits of the last byte above MICROCODE_WIDTH are discarded.
  - CSUM: 1 byte, equal to the XOR of every preceding frame byte, including both LEN bytes.
- States and transitions:
  - LEN_LO → LEN_HI → CHECK → DATA → CSUM → LEN_LO.
  - Any state → ERROR on a fault.
  - ERROR exits only via rst.
- Reset: state LEN_LO, in_ready=1, mem_we=0, mem_addr=0, mem_data=0, sequencer_rst=0, busy=0, done=0, error=0, running XOR=0, word and byte counters 0.
- in_ready:
  - 1 in LEN_LO, LEN_HI, DATA, CSUM and ERROR.
  - 0 in CHECK, which lasts exactly one cycle.
  - Gaps in in_valid are legal anywhere and cause no state change.
- Fields are latched on each accepted byte. The running XOR is updated on every accepted byte except the CSUM byte.
- LEN_LO accept: sequencer_rst is set to 1 from the next cycle.
- CHECK:
  - N==0 or N>PROGRAM_SIZE → ERROR; error=1 from the next cycle.
  - Otherwise → DATA with word index 0.
- DATA write on accepting byte BYTES_PER_WORD-1 of word k:
  - In the next cycle: mem_we=1 for one cycle, mem_addr=k, mem_data=assembled word.
  - After word N-1 → CSUM.
  - Write latency is 1 cycle after the final byte handshake.
- CSUM accept:
  - Match: next cycle sequencer_rst=0 and done=1 for one cycle; state → LEN_LO.
  - Mismatch: → ERROR; error=1; sequencer_rst stays 1.
- ERROR:
  - Bytes are accepted and discarded.
  - No writes; error and sequencer_rst stay high until rst.
  - Memory contents are undefined after an error (words may already have been written).
- rst mid-frame: immediate return to the reset values. Any write scheduled for the following cycle is cancelled. The partial program is abandoned and the next frame starts at address 0.
- Counters never wrap: the word index saturates at N-1 by construction, since N≤PROGRAM_SIZE.

Test Plan:
- Config: MICROCODE_WIDTH=16, PROGRAM_SIZE=200 for all scenarios.
- Good frame: stream 02 00 34 12 78 56 0A.
  - Writes (addr0, 0x1234) and (addr1, 0x5678), each 1 cycle after its final byte.
  - sequencer_rst high from the cycle after the first byte.
  - sequencer_rst low and done pulsed in the cycle after 0A; error=0.
- Bad checksum: same frame ending 0B.
  - Both writes occur, then error=1 and sequencer_rst stays 1.
  - Further bytes are accepted with in_ready=1 and produce no writes.
  - rst clears error and sequencer_rst.
- Length bounds:
  - 00 00 → error in the cycle after CHECK, no mem_we.
  - C9 00 (201) → error.
  - C8 00 (200) followed by 400 data bytes and correct CSUM → last write at addr 199, done pulsed.
- Handshake: in_valid toggles every other cycle through the good frame.
  - Identical writes and done.
  - in_ready=0 for exactly one cycle, the one after the LEN_HI handshake.
- Reset mid-load: assert rst after the first word of a 2-word frame.
  - Following cycle: mem_we=0, busy=0, sequencer_rst=0.
  - Then the good frame loads cleanly starting at addr 0.
